// File: rtl/pmem_arbiter_pkg.sv
// rtl/pmem_arbiter_pkg.sv - shared LC-3b types for the physical-memory arbiter
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } pmem_arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } pmem_arb_grant_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// rtl/pmem_arbiter_if.sv - line-sized pmem request/response bundle with requester/memory modports
interface pmem_arbiter_if;
    import lc3b_types::*;

    logic     read;
    logic     write;
    lc3b_word address;
    lc3b_line wdata;
    lc3b_line rdata;
    logic     resp;

    // Issues requests (cache controller, or the arbiter toward memory).
    modport master (
        output read, write, address, wdata,
        input  rdata, resp
    );

    // Serves requests (the arbiter toward a cache, or physical memory).
    modport slave (
        input  read, write, address, wdata,
        output rdata, resp
    );

endinterface

// File: rtl/pmem_arb_pick.sv
// rtl/pmem_arb_pick.sv - winner selection between pending I-cache and D-cache requests
module pmem_arb_pick
    import lc3b_types::*;
(
    input  logic            pend_i_i,
    input  logic            pend_d_i,
    input  pmem_arb_grant_t last_i,
    output pmem_arb_grant_t winner_o
);

    // A lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        winner_o = GRANT_D;
        if (pend_i_i && !pend_d_i) begin
            winner_o = GRANT_I;
        end else if (pend_i_i && pend_d_i) begin
            winner_o = (last_i == GRANT_D) ? GRANT_I : GRANT_D;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - I/D cache arbiter for the shared pmem port (PMEM_ARB_ROUND_ROBIN_EN selects round-robin ties)
module pmem_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst,
    pmem_arbiter_if.slave  icache_pmem,
    pmem_arbiter_if.slave  dcache_pmem,
    pmem_arbiter_if.master pmem
);

    pmem_arb_state_t state_q, state_d;
    pmem_arb_grant_t grant_q, grant_d;
    pmem_arb_grant_t winner;
    pmem_arb_grant_t last_grant;
    logic            read_q, read_d;
    logic            write_q, write_d;
    lc3b_word        address_q, address_d;
    lc3b_line        wdata_q, wdata_d;

    logic pend_i;
    logic pend_d;
    logic grant_now;

    assign pend_i    = icache_pmem.read | icache_pmem.write;
    assign pend_d    = dcache_pmem.read | dcache_pmem.write;
    assign grant_now = (state_q == IDLE) && (pend_i || pend_d);

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    pmem_arb_grant_t last_q, last_d;

    assign last_d     = grant_now ? winner : last_q;
    assign last_grant = last_q;

    // Remember who won the most recent grant so the other side wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) last_q <= GRANT_I;
        else     last_q <= last_d;
    end
`else
    // Pretending I-cache was granted last makes every tie go to the D-cache.
    assign last_grant = GRANT_I;
`endif

    pmem_arb_pick u_pick (
        .pend_i_i (pend_i),
        .pend_d_i (pend_d),
        .last_i   (last_grant),
        .winner_o (winner)
    );

    // Next state: latch the winner in IDLE, hold in BUSY until memory responds, one DONE turnaround.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        read_d    = read_q;
        write_d   = write_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_now) begin
                    grant_d = winner;
                    state_d = BUSY;
                    if (winner == GRANT_D) begin
                        write_d   = dcache_pmem.write;
                        read_d    = dcache_pmem.read & ~dcache_pmem.write;
                        address_d = dcache_pmem.address;
                        wdata_d   = dcache_pmem.wdata;
                    end else begin
                        write_d   = icache_pmem.write;
                        read_d    = icache_pmem.read & ~icache_pmem.write;
                        address_d = icache_pmem.address;
                        wdata_d   = icache_pmem.wdata;
                    end
                end
            end
            BUSY: begin
                if (pmem.resp) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // State and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= GRANT_I;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            read_q    <= read_d;
            write_q   <= write_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
        end
    end

    assign pmem.read    = read_q;
    assign pmem.write   = write_q;
    assign pmem.address = address_q;
    assign pmem.wdata   = wdata_q;

    assign icache_pmem.rdata = pmem.rdata;
    assign dcache_pmem.rdata = pmem.rdata;
    assign icache_pmem.resp  = (state_q == BUSY) && pmem.resp && (grant_q == GRANT_I);
    assign dcache_pmem.resp  = (state_q == BUSY) && pmem.resp && (grant_q == GRANT_D);

endmodule
